// File: rtl/vending_ctrl_multi.sv
// vending_ctrl_multi
//   Multi-slot vending controller. Collects coin credit (refusing coins that
//   would push credit past MAX_CREDIT), arms a sale when the selected slot is
//   affordable and in stock, vends one item and pays the change as a stream
//   of single-cycle hopper pulses, largest coin first.
//
//   Optional feature macro: MULTI_VEND_EN
//     defined   - a vend that leaves credit returns to CREDIT so the balance
//                 can be spent again; change is paid only on i_cancel.
//     undefined - the remainder of every vend is paid out immediately.
//
// Ports
//   clk, reset      clock, asynchronous active-low reset
//   i_coin[2:0]     coin lines (1/5/10 jiao), counted on falling edges
//   i_sel           selected slot
//   i_confirm       buy request
//   i_cancel        abort and refund
//   i_refill        reload all stock counters (IDLE only)
//   o_money         current credit
//   o_price         price of i_sel (0 for an invalid slot)
//   o_ready         sale armed
//   o_goods         one-cycle vend pulse
//   o_slot          slot latched at vend
//   o_sold_out      selected slot empty or invalid
//   o_reject        one-cycle pulse when a coin is refused
//   o_change        refund/change total latched on entering CHANGE
//   o_coin_out[2:0] one-hot hopper pulse (1/5/10 jiao)
//   o_busy          high in VEND, CHANGE, DONE
module vending_ctrl_multi #(
   parameter int MONEY_W    = 6,
   parameter int N_SLOT     = 4,
   parameter int SLOT_W     = 2,
   parameter int STOCK_W    = 4,
   parameter int STOCK_INIT = 5,
   parameter int MAX_CREDIT = 50,
   parameter logic [N_SLOT*MONEY_W-1:0] PRICE_TABLE = {6'd20, 6'd14, 6'd10, 6'd5}
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [2:0]        i_coin,
   input  logic [SLOT_W-1:0] i_sel,
   input  logic              i_confirm,
   input  logic              i_cancel,
   input  logic              i_refill,
   output logic [MONEY_W-1:0] o_money,
   output logic [MONEY_W-1:0] o_price,
   output logic              o_ready,
   output logic              o_goods,
   output logic [SLOT_W-1:0] o_slot,
   output logic              o_sold_out,
   output logic              o_reject,
   output logic [MONEY_W-1:0] o_change,
   output logic [2:0]        o_coin_out,
   output logic              o_busy
);

   // two spare bits: credit (<= MAX_CREDIT) plus up to 16 jiao in one cycle
   localparam int SUM_W = MONEY_W + 2;

   typedef enum logic [2:0] {IDLE, CREDIT, READY, VEND, CHANGE, DONE} state_t;

   state_t                         state;
   logic [MONEY_W-1:0]             money;
   logic [2:0]                     coin_q;
   logic [N_SLOT-1:0][STOCK_W-1:0] stock;
   logic [SLOT_W-1:0]              sel_q;

   logic [2:0]         fall;
   logic [SUM_W-1:0]   coin_sum;
   logic [SUM_W-1:0]   credit_sum;
   logic               coin_en;
   logic               over;
   logic               accept;
   logic               refuse;
   logic [MONEY_W-1:0] money_in;
   logic [MONEY_W-1:0] sel_price;
   logic               sel_empty;
   logic               afford;
   logic [MONEY_W-1:0] vend_price;
   logic [MONEY_W-1:0] vend_rem;
   logic [MONEY_W-1:0] step;
   logic [2:0]         pick;

   // Coin edges are tracked in every state so a coin dropped while busy can
   // never surface later as a stale edge.
   assign fall     = coin_q & ~i_coin;
   assign coin_sum = (fall[0] ? SUM_W'(1)  : '0)
                   + (fall[1] ? SUM_W'(5)  : '0)
                   + (fall[2] ? SUM_W'(10) : '0);
   assign coin_en    = (state == IDLE) || (state == CREDIT) || (state == READY);
   assign credit_sum = SUM_W'(money) + coin_sum;
   // all coins of one cycle are refused together
   assign over     = credit_sum > SUM_W'(MAX_CREDIT);
   assign accept   = coin_en && (coin_sum != '0) && !over;
   assign refuse   = coin_en && over;
   // credit including coins accepted this cycle; used wherever credit is
   // latched on the same edge as a coin could land (cancel)
   assign money_in = accept ? credit_sum[MONEY_W-1:0] : money;

   // Slot decode for the live selection and for the slot being vended.
   always_comb begin
      sel_price  = '0;
      sel_empty  = 1'b1;
      vend_price = '0;
      for (int k = 0; k < N_SLOT; k++) begin
         if (i_sel == SLOT_W'(k)) begin
            sel_price = PRICE_TABLE[k*MONEY_W +: MONEY_W];
            sel_empty = (stock[k] == '0);
         end
         if (sel_q == SLOT_W'(k))
            vend_price = PRICE_TABLE[k*MONEY_W +: MONEY_W];
      end
   end

   assign afford   = (money >= sel_price) && !sel_empty;
   assign vend_rem = (money >= vend_price) ? money - vend_price : '0;

   // Greedy hopper coin choice for the current remaining change.
   always_comb begin
      step = MONEY_W'(1);
      pick = 3'b001;
      if (money >= MONEY_W'(10)) begin
         step = MONEY_W'(10);
         pick = 3'b100;
      end else if (money >= MONEY_W'(5)) begin
         step = MONEY_W'(5);
         pick = 3'b010;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         money      <= '0;
         coin_q     <= '0;
         stock      <= {N_SLOT{STOCK_W'(STOCK_INIT)}};
         sel_q      <= '0;
         o_goods    <= 1'b0;
         o_slot     <= '0;
         o_reject   <= 1'b0;
         o_change   <= '0;
         o_coin_out <= '0;
      end else begin
         coin_q     <= i_coin;
         o_goods    <= 1'b0;
         o_reject   <= refuse;
         o_coin_out <= '0;
         if (accept)
            money <= money_in;

         case (state)
            IDLE: begin
               if (i_refill)
                  stock <= {N_SLOT{STOCK_W'(STOCK_INIT)}};
               if (money != '0)
                  state <= CREDIT;
            end

            CREDIT: begin
               if (i_cancel) begin
                  o_change <= money_in;
                  state    <= (money_in != '0) ? CHANGE : DONE;
               end else if (afford) begin
                  state <= READY;
               end
            end

            READY: begin
               if (i_cancel) begin
                  o_change <= money_in;
                  state    <= (money_in != '0) ? CHANGE : DONE;
               end else if (i_confirm && afford) begin
                  // the confirm cycle is gated by affordability too, so a
                  // selection switched on that very cycle cannot underflow
                  state   <= VEND;
                  o_goods <= 1'b1;
                  o_slot  <= i_sel;
                  sel_q   <= i_sel;
               end else if (!afford) begin
                  state <= CREDIT;
               end
            end

            VEND: begin
               for (int k = 0; k < N_SLOT; k++)
                  if (sel_q == SLOT_W'(k) && stock[k] != '0)
                     stock[k] <= stock[k] - STOCK_W'(1);
               money <= vend_rem;
               if (vend_rem != '0) begin
`ifdef MULTI_VEND_EN
                  state <= CREDIT;
`else
                  o_change <= vend_rem;
                  state    <= CHANGE;
`endif
               end else begin
                  state <= DONE;
               end
            end

            CHANGE: begin
               o_coin_out <= pick;
               if (money <= step) begin
                  money <= '0;
                  state <= DONE;
               end else begin
                  money <= money - step;
               end
            end

            DONE: begin
               // wait for the front end to go quiet before taking new work
               if (!i_confirm && !i_cancel && i_coin == 3'b000) begin
                  state    <= IDLE;
                  o_change <= '0;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

   assign o_money    = money;
   assign o_price    = sel_price;
   assign o_sold_out = sel_empty;
   assign o_ready    = (state == READY);
   assign o_busy     = (state == VEND) || (state == CHANGE) || (state == DONE);

endmodule

// File: doc/vending_ctrl_multi.md
Name: vending_ctrl_multi

Overview:
Parametrised successor to the single-product vending controller. Serves N_SLOT products, each with its own price and stock counter. Accumulates coin credit with overflow rejection, then vends and pays change coin-by-coin as a pulse stream for the coin hopper. Sits between the coin acceptor/keypad front end and the dispenser/hopper drivers.

Parameters:
MONEY_W, 6, credit/price width in jiao (0.1 yuan units)
N_SLOT, 4, number of product slots
SLOT_W, 2, slot index width; must satisfy 2^SLOT_W >= N_SLOT
STOCK_W, 4, per-slot stock counter width
STOCK_INIT, 5, stock loaded at reset and on refill
MAX_CREDIT, 50, maximum credit accepted in jiao; must be < 2^MONEY_W
PRICE_TABLE, {6'd20,6'd14,6'd10,6'd5}, packed prices; slot k uses bits [k*MONEY_W +: MONEY_W]

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
i_coin  in  3  coin acceptor lines: bit0=1 jiao, bit1=5 jiao, bit2=10 jiao; a coin is counted on the bit's falling edge
i_sel  in  SLOT_W  selected slot
i_confirm  in  1  buy request
i_cancel  in  1  abort and refund
i_refill  in  1  reload all stock counters to STOCK_INIT
o_money  out  MONEY_W  current credit
o_price  out  MONEY_W  price of slot i_sel; 0 if i_sel >= N_SLOT
o_ready  out  1  high in READY
o_goods  out  1  one-cycle vend pulse
o_slot  out  SLOT_W  slot latched at VEND
o_sold_out  out  1  level: stock of i_sel is 0 or i_sel is invalid
o_reject  out  1  one-cycle pulse when a coin is refused
o_change  out  MONEY_W  total refund/change amount latched on CHANGE entry
o_coin_out  out  3  one-hot one-cycle hopper pulse: bit0=1, bit1=5, bit2=10 jiao
o_busy  out  1  high in VEND, CHANGE, DONE

Behaviour:
- Reset values: all outputs 0; money 0; coin history register 0; all stocks = STOCK_INIT; state IDLE.
- Coin detection is active in IDLE, CREDIT and READY only. Per cycle, take the sum of values of all bits falling simultaneously (each one counted, none overwritten).
- If money + sum > MAX_CREDIT, the whole cycle's coins are refused: o_reject pulses and money is unchanged. Otherwise money += sum, registered, visible the next cycle.
- States: IDLE, CREDIT, READY, VEND, CHANGE, DONE.
- IDLE: money != 0 -> CREDIT. i_refill reloads stocks; i_refill is ignored in every other state.
- CREDIT: i_cancel -> CHANGE (full refund). Else if money >= price(i_sel) and the slot is not sold out -> READY.
- READY: priority is cancel > confirm > re-check.
  - i_cancel -> CHANGE.
  - i_confirm -> VEND.
  - Else if i_sel changes so that money < price or the slot is sold out -> CREDIT.
- VEND (1 cycle): o_goods=1; o_slot=i_sel; stock[sel] -= 1; money -= price(sel), never underflows. Next state is CHANGE if money-price > 0, otherwise DONE.
- CHANGE entry: o_change <= money.
- CHANGE, each cycle: dispense exactly one coin, greedy.
  - money >= 10: bit2, money -= 10.
  - else money >= 5: bit1, money -= 5.
  - else: bit0, money -= 1.
  - After the coin that brings money to 0 -> DONE.
  - Cycles spent = floor(c/10) + floor((c%10)/5) + c%5.
- DONE: i_confirm, i_cancel and i_coin all low -> IDLE and o_change <= 0. Otherwise stay in DONE.
- Coins inserted during VEND/CHANGE/DONE are not counted. The coin history register still tracks i_coin so that no stale edge is counted later.
- Stock never decrements below 0 (guaranteed by the READY gating).
- Asynchronous reset mid-operation aborts immediately. Credit is lost and no further hopper pulses occur.

Optional Feature:
MULTI_VEND_EN
- Defined: VEND with remaining credit > 0 returns to CREDIT, keeping the balance for further purchases. Change is paid only on i_cancel. VEND with zero remainder goes to DONE.
- Undefined: behaviour exactly as above; remainder is always paid out immediately.

Test Plan:
- Slot 2 (price 14): insert 10, 5 (falling edges on separate cycles), i_confirm -> o_goods pulse, stock[2] 5->4, o_change=1, one bit0 pulse, DONE -> IDLE.
- Credit 0, insert 10,10,10 then select slot 0 (price 5), confirm -> o_change=25, pulses bit2,bit2,bit1 on 3 consecutive cycles, money 0.
- Credit 45, insert 10 -> o_reject pulse, o_money stays 45. Same-cycle fall of bits 0 and 1 from credit 0 -> o_money=6.
- Buy slot 3 (price 20) five times -> stock 0, o_sold_out=1, credit 20 stays in CREDIT. i_cancel -> refund 20 as two bit2 pulses. i_refill in IDLE -> o_sold_out=0.
- In READY for slot 0 with credit 10, switch i_sel to slot 3 -> back to CREDIT, o_ready=0. Assert i_cancel and i_confirm together in READY -> refund, no o_goods.
- MULTI_VEND_EN: credit 30, buy slot 1 (price 10) -> CREDIT with o_money=20, no o_coin_out. Buy slot 1 again -> o_money=10. i_cancel -> single bit2 pulse.
